// File: rtl/pcp_pkg.sv
// Shared constants and stage payload types for the pipelined Kogge-Stone adder.
package pcp_pkg;
  localparam int WIDTH  = 8;
  localparam int LEVELS = 3;
  localparam int SPAN1  = 1;
  localparam int SPAN2  = 2;
  localparam int SPAN3  = 4;

  // lv is 0-based: level 0 feeds S1, level 1 feeds S2, level 2 feeds S3.
  function automatic int span_of(input int lv);
    case (lv)
      0:       return SPAN1;
      1:       return SPAN2;
      default: return SPAN3;
    endcase
  endfunction

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] po;
    logic             cin;
  } stage_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;
endpackage

// File: rtl/prefix_cell.sv
// Kogge-Stone prefix operator: (Gh,Ph) o (Gl,Pl) = (Gh | Ph&Gl, Ph&Pl).
module prefix_cell (
  input  logic gh_i,
  input  logic ph_i,
  input  logic gl_i,
  input  logic pl_i,
  output logic g_o,
  output logic p_o
);
  assign g_o = gh_i | (ph_i & gl_i);
  assign p_o = ph_i & pl_i;
endmodule

// File: rtl/prefix_carry_pipe.sv
// Three-stage pipelined Kogge-Stone carry network with valid/ready handshake.
module prefix_carry_pipe #(
  parameter int WIDTH  = pcp_pkg::WIDTH,
  parameter int LEVELS = pcp_pkg::LEVELS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  import pcp_pkg::*;

  logic [LEVELS-1:0][WIDTH-1:0] src_g, src_p, dst_g, dst_p;
  stage_t s1_d, s1_q, s2_d, s2_q;
  res_t   s3_d, s3_q;
  logic [LEVELS:1]   vld_q;
  logic [LEVELS+1:1] rdy;
  logic [WIDTH-1:0]  c;
  logic              unused_p;

  // A stage can load when empty or when its contents move on this cycle.
  assign rdy[LEVELS+1] = out_ready;
  for (genvar k = 1; k <= LEVELS; k++) begin : g_rdy
    assign rdy[k] = !vld_q[k] | rdy[k+1];
  end
  assign in_ready = rdy[1];

  // cin is folded into bit 0 so the final G vector is the carry out of each bit.
  assign src_g[0] = {g[WIDTH-1:1], g[0] | (p[0] & cin)};
  assign src_p[0] = p;
  assign src_g[1] = s1_q.g;
  assign src_p[1] = s1_q.p;
  assign src_g[2] = s2_q.g;
  assign src_p[2] = s2_q.p;

  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= span_of(lv)) begin : g_cell
        prefix_cell u_cell (
          .gh_i(src_g[lv][i]),
          .ph_i(src_p[lv][i]),
          .gl_i(src_g[lv][i-span_of(lv)]),
          .pl_i(src_p[lv][i-span_of(lv)]),
          .g_o (dst_g[lv][i]),
          .p_o (dst_p[lv][i])
        );
      end else begin : g_pass
        assign dst_g[lv][i] = src_g[lv][i];
        assign dst_p[lv][i] = src_p[lv][i];
      end
    end
  end

  // Group propagate out of the last level is not needed for the sum.
  assign unused_p = ^dst_p[LEVELS-1];

  assign s1_d = '{g: dst_g[0], p: dst_p[0], po: p,       cin: cin};
  assign s2_d = '{g: dst_g[1], p: dst_p[1], po: s1_q.po, cin: s1_q.cin};

  assign c         = {dst_g[2][WIDTH-2:0], s2_q.cin};
  assign s3_d.sum  = s2_q.po ^ c;
  assign s3_d.cout = dst_g[2][WIDTH-1];
  assign s3_d.ovf  = dst_g[2][WIDTH-1] ^ dst_g[2][WIDTH-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
    end else begin
      if (rdy[1]) vld_q[1] <= in_valid;
      if (rdy[2]) vld_q[2] <= vld_q[1];
      if (rdy[3]) vld_q[3] <= vld_q[2];
      if (rdy[1] && in_valid) s1_q <= s1_d;
      if (rdy[2] && vld_q[1]) s2_q <= s2_d;
      if (rdy[3] && vld_q[2]) s3_q <= s3_d;
    end
  end

  assign sum       = s3_q.sum;
  assign cout      = s3_q.cout;
  assign ovf       = s3_q.ovf;
  assign out_valid = vld_q[3];
endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Table-driven and scoreboard bench for prefix_carry_pipe.
module tb_prefix_carry_pipe;
  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] g;
    logic       cin;
    res_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] p, g;
  logic       cin, in_valid, in_ready;
  logic [7:0] sum;
  logic       cout, ovf, out_valid, out_ready;

  int   errors = 0;
  int   checks = 0;
  res_t sb[$];
  res_t exp_cur;
  logic rnd_bp = 1'b0;
  logic prev_stall = 1'b0;
  logic [9:0] held;
  vec_t tbl [8];

  always #5 clk = ~clk;

  prefix_carry_pipe dut (
    .clk(clk), .rst_n(rst_n), .p(p), .g(g), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: with p&g==0, a=p|g and b=g reproduce the given propagate/generate.
  function automatic res_t model(input logic [7:0] pp, input logic [7:0] gg, input logic cc);
    logic [8:0] full;
    logic [7:0] low;
    res_t r;
    full   = {1'b0, pp | gg} + {1'b0, gg} + {8'd0, cc};
    low    = {1'b0, (pp[6:0] | gg[6:0])} + {1'b0, gg[6:0]} + {7'd0, cc};
    r.sum  = full[7:0];
    r.cout = full[8];
    r.ovf  = low[7] ^ full[8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {out_valid, sum, cout, ovf}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious out_valid=1 sum=%0h with no result expected at %0t", sum, $time);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("sb", {sum, cout, ovf}, {e.sum, e.cout, e.ovf});
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_cur);
      prev_stall = out_valid && !out_ready;
      held = {sum, cout, ovf};
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] pp, input logic [7:0] gg, input logic cc, input res_t e);
    int n = 0;
    p = pp; g = gg; cin = cc; exp_cur = e; in_valid = 1'b1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [7:0] rp, rg;
    logic rc;
    res_t e;

    tbl[0] = '{8'h0E, 8'h01, 1'b0, '{8'h10, 1'b0, 1'b0}};
    tbl[1] = '{8'hFE, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}};
    tbl[2] = '{8'hFF, 8'h00, 1'b1, '{8'h00, 1'b1, 1'b0}};
    tbl[3] = '{8'h7E, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1}};
    tbl[4] = '{8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0}};
    tbl[5] = '{8'h00, 8'h00, 1'b1, '{8'h01, 1'b0, 1'b0}};
    tbl[6] = '{8'h00, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1}};
    tbl[7] = '{8'h55, 8'hAA, 1'b1, '{8'hAA, 1'b1, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; p = '0; g = '0; cin = 1'b0; out_ready = 1'b1;
    exp_cur = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", {cout, ovf}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency of a lone operation: valid three edges after acceptance.
    send(tbl[0].p, tbl[0].g, tbl[0].cin, tbl[0].exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("latency", 32'(n), 32'd3);
    drain();

    for (int i = 0; i < 8; i++) send(tbl[i].p, tbl[i].g, tbl[i].cin, tbl[i].exp);
    drain();

    // Backpressure: three fill the pipe, the rest wait for out_ready.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(tbl[i+1].p, tbl[i+1].g, tbl[i+1].cin, tbl[i+1].exp);
    @(negedge clk);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    p = 8'h12; g = 8'h21; cin = 1'b0; exp_cur = model(8'h12, 8'h21, 1'b0); in_valid = 1'b1;
    @(negedge clk);
    chk("bp_emit0", {out_valid, in_ready}, 32'd3);
    @(posedge clk); #1;
    p = 8'h0F; g = 8'hF0; cin = 1'b1; exp_cur = model(8'h0F, 8'hF0, 1'b1);
    @(negedge clk);
    chk("bp_emit1", {out_valid, in_ready}, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_emit%0d", i), 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    drain();

    // Random traffic under random backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rp = 8'($urandom);
      rg = 8'($urandom) & ~rp;
      rc = 1'($urandom);
      send(rp, rg, rc, model(rp, rg, rc));
    end
    rnd_bp = 1'b0;
    drain();

    // Reset mid-stream with two operations in flight.
    out_ready = 1'b0;
    send(8'h3C, 8'h41, 1'b1, model(8'h3C, 8'h41, 1'b1));
    send(8'h05, 8'h0A, 1'b0, model(8'h05, 8'h0A, 1'b0));
    @(posedge clk); #1;
    chk("mid_out_valid_before", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_clear", {out_valid, sum, cout, ovf}, 32'd0);
    sb.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("mid_no_stale", 32'(n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
